ps2_mouse_rx: RTL

//  Receives the raw PS/2 device-to-host serial stream from the mouse port and assembles 3-byte packets.

---
 rtl/ps2_mouse_pkg.sv | 20 ++
 rtl/ps2_rx_byte.sv | 131 +++++++++++++
 rtl/ps2_mouse_rx.sv | 89 ++++++++
 3 files changed

// File: rtl/ps2_mouse_pkg.sv
// rtl/ps2_mouse_pkg.sv - shared PS/2 mouse frame constants, FSM states and bus field offsets
package ps2_mouse_pkg;
    localparam int DATA_BITS   = 8;
    localparam int PKT_BYTES   = 3;
    localparam int B0_SYNC_BIT = 3;

    // ps2_mouse bus layout, also consumed by the quadrature stage
    localparam int MOUSE_W          = 25;
    localparam int MOUSE_STATUS_LSB = 0;
    localparam int MOUSE_X_LSB      = 8;
    localparam int MOUSE_Y_LSB      = 16;
    localparam int MOUSE_TOGGLE_BIT = 24;

    typedef enum logic {BYTE_IDLE, BYTE_BITS} byte_state_t;
    typedef enum logic [1:0] {PKT_B0, PKT_B1, PKT_B2} pkt_state_t;

    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction
endpackage

// File: rtl/ps2_rx_byte.sv
// rtl/ps2_rx_byte.sv - PS/2 line conditioning, idle qualification and byte framing
module ps2_rx_byte
    import ps2_mouse_pkg::*;
#(
    parameter int FILTER_LEN      = 4,
    parameter int BIT_TIMEOUT_CYC = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ps2_clk_i,
    input  logic                 ps2_data_i,
    output logic                 byte_vld,
    output logic [DATA_BITS-1:0] byte_data,
    output logic                 frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(BIT_TIMEOUT_CYC + 1);

    logic [1:0]          clk_sync, data_sync;
    logic [FW-1:0]       clk_fcnt, data_fcnt;
    logic                clk_filt, data_filt, clk_filt_d;
    logic [TW-1:0]       idle_cnt, bit_timer;
    logic                line_idle;
    byte_state_t         state_q, state_d;
    logic [3:0]          bitcnt;
    logic [DATA_BITS:0]  shift;
    logic                edge_ok, bit_timeout, last_bit;

    assign edge_ok     = clk_filt_d & ~clk_filt & line_idle;
    assign bit_timeout = (state_q == BYTE_BITS) && (bit_timer == TW'(BIT_TIMEOUT_CYC));
    assign last_bit    = (bitcnt == 4'(DATA_BITS + 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            clk_fcnt   <= '0;
            data_fcnt  <= '0;
            clk_filt   <= 1'b1;
            data_filt  <= 1'b1;
            clk_filt_d <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk_i};
            data_sync  <= {data_sync[0], ps2_data_i};
            clk_filt_d <= clk_filt;
            // level only moves after FILTER_LEN consecutive disagreeing samples
            if (clk_sync[1] == clk_filt) begin
                clk_fcnt <= '0;
            end else if (clk_fcnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                clk_fcnt <= '0;
            end else begin
                clk_fcnt <= clk_fcnt + 1'b1;
            end
            if (data_sync[1] == data_filt) begin
                data_fcnt <= '0;
            end else if (data_fcnt == FW'(FILTER_LEN - 1)) begin
                data_filt <= data_sync[1];
                data_fcnt <= '0;
            end else begin
                data_fcnt <= data_fcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt  <= '0;
            line_idle <= 1'b0;
        end else if (bit_timeout) begin
            idle_cnt  <= '0;
            line_idle <= 1'b0;
        end else if (!clk_filt) begin
            idle_cnt <= '0;
        end else if (idle_cnt == TW'(BIT_TIMEOUT_CYC)) begin
            line_idle <= 1'b1;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= BYTE_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BYTE_IDLE: if (edge_ok && !data_filt) state_d = BYTE_BITS;
            BYTE_BITS: if (bit_timeout || (edge_ok && last_bit)) state_d = BYTE_IDLE;
            default:   state_d = BYTE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            byte_data <= '0;
            bitcnt    <= '0;
            bit_timer <= '0;
            shift     <= '0;
        end else begin
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            if (state_q == BYTE_IDLE) begin
                bitcnt    <= '0;
                bit_timer <= '0;
            end else if (bit_timeout) begin
                frame_err <= 1'b1;
            end else if (edge_ok) begin
                bit_timer <= '0;
                if (last_bit) begin
                    if (data_filt && odd_parity_ok(shift[DATA_BITS-1:0], shift[DATA_BITS])) begin
                        byte_vld  <= 1'b1;
                        byte_data <= shift[DATA_BITS-1:0];
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    // LSB-first: after 9 shifts data sits in [7:0], parity in [8]
                    shift  <= {data_filt, shift[DATA_BITS:1]};
                    bitcnt <= bitcnt + 1'b1;
                end
            end else begin
                bit_timer <= bit_timer + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ps2_mouse_rx.sv
// rtl/ps2_mouse_rx.sv - PS/2 mouse receiver: 3-byte packet assembly onto the ps2_mouse bus
module ps2_mouse_rx
    import ps2_mouse_pkg::*;
#(
    parameter int FILTER_LEN      = 4,
    parameter int BIT_TIMEOUT_CYC = 50000,
    parameter int PKT_TIMEOUT_CYC = 500000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ps2_clk_i,
    input  logic               ps2_data_i,
    output logic [MOUSE_W-1:0] ps2_mouse,
    output logic               rx_err,
    output logic               sync_err
);
    localparam int PW = $clog2(PKT_TIMEOUT_CYC + 1);

    logic                                byte_vld, frame_err;
    logic [DATA_BITS-1:0]                byte_data;
    logic [PKT_BYTES-2:0][DATA_BITS-1:0] held;
    pkt_state_t                          pkt_q, pkt_d;
    logic [PW-1:0]                       pkt_timer;
    logic                                pkt_timeout, take;

    ps2_rx_byte #(
        .FILTER_LEN      (FILTER_LEN),
        .BIT_TIMEOUT_CYC (BIT_TIMEOUT_CYC)
    ) u_byte (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .byte_vld   (byte_vld),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    assign rx_err      = frame_err;
    assign pkt_timeout = (pkt_q != PKT_B0) && (pkt_timer == PW'(PKT_TIMEOUT_CYC));
    // a timeout landing on the same cycle as a byte drops that byte too
    assign take        = byte_vld && !frame_err && !pkt_timeout;

    always_ff @(posedge clk) begin
        if (reset) pkt_q <= PKT_B0;
        else       pkt_q <= pkt_d;
    end

    always_comb begin
        pkt_d = pkt_q;
        if (frame_err || pkt_timeout) begin
            pkt_d = PKT_B0;
        end else if (take) begin
            case (pkt_q)
                PKT_B0:  if (byte_data[B0_SYNC_BIT]) pkt_d = PKT_B1;
                PKT_B1:  pkt_d = PKT_B2;
                default: pkt_d = PKT_B0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_timer <= '0;
            held      <= '0;
            ps2_mouse <= '0;
            sync_err  <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            if (pkt_q == PKT_B0 || byte_vld) pkt_timer <= '0;
            else if (!pkt_timeout)           pkt_timer <= pkt_timer + 1'b1;
            if (take) begin
                case (pkt_q)
                    PKT_B0: begin
                        if (byte_data[B0_SYNC_BIT]) held[0] <= byte_data;
                        else                        sync_err <= 1'b1;
                    end
                    PKT_B1: held[1] <= byte_data;
                    default: begin
                        ps2_mouse[MOUSE_Y_LSB +: DATA_BITS]      <= byte_data;
                        ps2_mouse[MOUSE_X_LSB +: DATA_BITS]      <= held[1];
                        ps2_mouse[MOUSE_STATUS_LSB +: DATA_BITS] <= held[0];
                        ps2_mouse[MOUSE_TOGGLE_BIT]              <= ~ps2_mouse[MOUSE_TOGGLE_BIT];
                    end
                endcase
            end
        end
    end
endmodule
